// File: rtl/mac_pkg.sv
// mac_pkg: shared types, width limits and the result conversion used by the MAC array.
package mac_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} pe_state_t;

    localparam int MAX_W = 64;

    function automatic bit widths_ok(input int data_w, input int acc_w, input int out_w);
        return acc_w >= 2 * data_w && out_w <= acc_w && acc_w < MAX_W;
    endfunction

    // x arrives already sign- or zero-extended to MAX_W; the caller keeps the low out_w bits.
    function automatic logic [MAX_W-1:0] sat_conv(input logic [MAX_W-1:0] x, input int out_w,
                                                   input bit sgn, input bit sat);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = sgn ? (64'sd1 <<< (out_w - 1)) - 64'sd1 : (64'sd1 <<< out_w) - 64'sd1;
        lo = sgn ? -(64'sd1 <<< (out_w - 1)) : '0;
        if (!sat) return x;
        if (sgn) return $signed(x) > hi ? hi : $signed(x) < lo ? lo : x;
        return x > hi ? hi : x;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// mac_sat: combinational accumulator-to-result conversion, clamping or truncating.
module mac_sat import mac_pkg::*; #(
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] res
);

    logic fill;

    assign fill = SIGNED != 0 ? acc[ACC_W-1] : 1'b0;
    assign res  = OUT_W'(sat_conv({{(MAX_W-ACC_W){fill}}, acc}, OUT_W, SIGNED != 0, SATURATE != 0));

endmodule

// File: rtl/mac_pe.sv
// mac_pe: output-stationary systolic MAC cell with operand forwarding,
// framed accumulation and one stage of the column result drain chain.
module mac_pe import mac_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic              a_first_in,
    input  logic              a_last_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic              a_first_out,
    output logic              a_last_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic              shift_en,
    input  logic [OUT_W-1:0]  res_in,
    input  logic              res_valid_in,
    output logic [OUT_W-1:0]  res_out,
    output logic              res_valid_out,
    output logic              busy,
    input  logic              err_clr,
    output logic              seq_err,
    output logic              collision
);

    if (!widths_ok(DATA_W, ACC_W, OUT_W)) begin : g_bad_widths
        $error("mac_pe: need ACC_W >= 2*DATA_W, OUT_W <= ACC_W, ACC_W < 64");
    end

    logic [DATA_W-1:0]          a_q, a_d, b_q, b_d;
    logic                       a_valid_q, a_valid_d, a_first_q, a_first_d, a_last_q, a_last_d;
    logic                       b_valid_q, b_valid_d;
    logic [OUT_W-1:0]           res_q, res_d, conv;
    logic                       res_valid_q, res_valid_d;
    logic                       seq_err_q, seq_err_d, collision_q, collision_d;
    logic [ACC_W-1:0]           acc_q, acc_d, acc_next, prod;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0]        prod_u;
    logic                       fire, capture, seq_set, coll_set;
    pe_state_t                  state_q, state_d;

    assign prod_s   = $signed(a_in) * $signed(b_in);
    assign prod_u   = a_in * b_in;
    assign prod     = SIGNED != 0 ? ACC_W'(prod_s) : ACC_W'(prod_u);
    assign fire     = a_valid_in & b_valid_in;
    assign capture  = fire & a_last_in;
    // A first tag always restarts the sum, even mid-frame.
    assign acc_next = (state_q == ACCUM && !a_first_in) ? acc_q + prod : prod;
    assign seq_set  = fire & (state_q == IDLE ? !a_first_in : a_first_in);
    assign coll_set = capture & ((res_valid_q & !shift_en) | (shift_en & res_valid_in));

    mac_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SIGNED(SIGNED), .SATURATE(SATURATE)) u_sat (
        .acc (acc_next),
        .res (conv)
    );

    always_comb begin
        a_d         = a_valid_in ? a_in : a_q;
        b_d         = b_valid_in ? b_in : b_q;
        a_valid_d   = a_valid_in;
        a_first_d   = a_first_in;
        a_last_d    = a_last_in;
        b_valid_d   = b_valid_in;
        acc_d       = fire ? acc_next : acc_q;
        state_d     = !fire ? state_q : a_last_in ? IDLE : ACCUM;
        res_d       = capture ? conv : shift_en ? res_in : res_q;
        res_valid_d = capture ? 1'b1 : shift_en ? res_valid_in : res_valid_q;
        seq_err_d   = seq_set | (seq_err_q & !err_clr);
        collision_d = coll_set | (collision_q & !err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            a_valid_q   <= 1'b0;
            a_first_q   <= 1'b0;
            a_last_q    <= 1'b0;
            b_valid_q   <= 1'b0;
            acc_q       <= '0;
            state_q     <= IDLE;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            a_valid_q   <= a_valid_d;
            a_first_q   <= a_first_d;
            a_last_q    <= a_last_d;
            b_valid_q   <= b_valid_d;
            acc_q       <= acc_d;
            state_q     <= state_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            seq_err_q   <= seq_err_d;
            collision_q <= collision_d;
        end
    end

    assign a_out         = a_q;
    assign a_valid_out   = a_valid_q;
    assign a_first_out   = a_first_q;
    assign a_last_out    = a_last_q;
    assign b_out         = b_q;
    assign b_valid_out   = b_valid_q;
    assign res_out       = res_q;
    assign res_valid_out = res_valid_q;
    assign busy          = state_q == ACCUM;
    assign seq_err       = seq_err_q;
    assign collision     = collision_q;

endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: four PEs (0,1 default and chained, 2 truncating, 3 unsigned) fed a shared
// operand stream with per-PE enables; frame results are scoreboarded.
module tb_mac_pe;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        av = 1'b0, bv = 1'b0, af = 1'b0, al = 1'b0;
    logic [3:0]  en = '0;
    logic        shift_en = 1'b0, err_clr = 1'b0;
    logic [15:0] tb_res = '0;
    logic        tb_rv = 1'b0;

    logic [7:0]  a_o [4];
    logic [7:0]  b_o [4];
    logic        av_o [4], af_o [4], al_o [4], bv_o [4];
    logic [15:0] res [4];
    logic        rv [4], busy [4], seq [4], coll [4];

    exp_t   sb_q [$];
    longint sum [4];
    bit     act [4];
    int     n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_pe
        mac_pe #(.DATA_W(8), .ACC_W(24), .OUT_W(16),
                 .SIGNED(i == 3 ? 0 : 1), .SATURATE(i == 2 ? 0 : 1)) u_pe (
            .clk           (clk),
            .reset_n       (reset_n),
            .a_in          (a),
            .a_valid_in    (av & en[i]),
            .a_first_in    (af),
            .a_last_in     (al),
            .b_in          (b),
            .b_valid_in    (bv & en[i]),
            .a_out         (a_o[i]),
            .a_valid_out   (av_o[i]),
            .a_first_out   (af_o[i]),
            .a_last_out    (al_o[i]),
            .b_out         (b_o[i]),
            .b_valid_out   (bv_o[i]),
            .shift_en      (i < 2 ? shift_en : 1'b0),
            .res_in        (i == 1 ? res[0] : tb_res),
            .res_valid_in  (i == 1 ? rv[0] : tb_rv),
            .res_out       (res[i]),
            .res_valid_out (rv[i]),
            .busy          (busy[i]),
            .err_clr       (err_clr),
            .seq_err       (seq[i]),
            .collision     (coll[i])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] conv(input longint s, input int i);
        bit     sg = (i != 3);
        bit     sat = (i != 2);
        longint w = s & 64'hFF_FFFF;
        if (sg && w[23]) w -= 64'h100_0000;
        if (sat && sg) w = w > 32767 ? 32767 : (w < -32768 ? -32768 : w);
        if (sat && !sg) w = w > 65535 ? 65535 : w;
        return w[15:0];
    endfunction

    task automatic beat(input logic [7:0] ta, input logic [7:0] tb_v, input bit f, input bit l,
                        input logic [3:0] e);
        longint p;
        exp_t   x;
        a = ta; b = tb_v; av = 1'b1; bv = 1'b1; af = f; al = l; en = e;
        for (int i = 0; i < 4; i++) begin
            if (e[i]) begin
                p = (i != 3) ? longint'($signed(ta)) * longint'($signed(tb_v))
                             : longint'(ta) * longint'(tb_v);
                sum[i] = (act[i] && !f) ? sum[i] + p : p;
                act[i] = !l;
                if (l) begin
                    x.idx = i;
                    x.val = conv(sum[i], i);
                    sb_q.push_back(x);
                end
            end
        end
        @(posedge clk);
        #1;
        av = 1'b0; bv = 1'b0; af = 1'b0; al = 1'b0;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check($sformatf("res_out[%0d]", x.idx), 32'(res[x.idx]), 32'(x.val));
            check($sformatf("res_valid[%0d]", x.idx), 32'(rv[x.idx]), 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b0;
            sum[i] = 0;
        end
        repeat (2) @(negedge clk);
        check("rst res_out", 32'(res[0]), 32'd0);
        check("rst res_valid", 32'(rv[0]), 32'd0);
        check("rst busy", 32'(busy[0]), 32'd0);
        check("rst seq_err", 32'(seq[0]), 32'd0);
        check("rst collision", 32'(coll[0]), 32'd0);
        check("rst a_valid_out", 32'(av_o[0]), 32'd0);
        reset_n = 1'b1;

        // 3*2 + (-4)*5 + 127*127 = 16115
        beat(8'd3, 8'd2, 1, 0, 4'b0001);
        check("busy in frame", 32'(busy[0]), 32'd1);
        check("a_out fwd", 32'(a_o[0]), 32'd3);
        check("a_first_out fwd", 32'(af_o[0]), 32'd1);
        beat(8'hFC, 8'd5, 0, 0, 4'b0001);
        check("res_valid mid frame", 32'(rv[0]), 32'd0);
        beat(8'd127, 8'd127, 0, 1, 4'b0001);
        check("seq_err clean frame", 32'(seq[0]), 32'd0);
        check("busy after last", 32'(busy[0]), 32'd0);
        check("a_last_out fwd", 32'(al_o[0]), 32'd1);

        // (-128)*(-128) x4 = 65536: PE0 clamps, PE2 truncates, PE3 sees 128*128 unsigned
        beat(8'h80, 8'h80, 1, 0, 4'b1101);
        beat(8'h80, 8'h80, 0, 0, 4'b1101);
        beat(8'h80, 8'h80, 0, 0, 4'b1101);
        beat(8'h80, 8'h80, 0, 1, 4'b1101);
        check("collision overwrite", 32'(coll[0]), 32'd1);
        check("no collision first capture", 32'(coll[2]), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("collision cleared", 32'(coll[0]), 32'd0);

        beat(8'hFF, 8'hFF, 1, 1, 4'b1000);
        check("u a_out", 32'(a_o[3]), 32'hFF);
        check("u b_out", 32'(b_o[3]), 32'hFF);
        check("u a_valid_out", 32'(av_o[3]), 32'd1);
        check("u b_valid_out", 32'(bv_o[3]), 32'd1);
        tick();
        check("a_valid_out drop", 32'(av_o[3]), 32'd0);
        check("a_out hold", 32'(a_o[3]), 32'hFF);

        beat(8'd5, 8'd2, 1, 1, 4'b0001);
        beat(8'd4, 8'd5, 1, 1, 4'b0010);
        err_clr = 1'b1;
        tb_res = 16'd99; tb_rv = 1'b1; shift_en = 1'b1;
        tick();
        err_clr = 1'b0;
        check("drain1 pe1", 32'(res[1]), 32'd10);
        check("drain1 pe1 valid", 32'(rv[1]), 32'd1);
        check("drain1 pe0", 32'(res[0]), 32'd99);
        tb_res = 16'd0; tb_rv = 1'b0;
        tick();
        check("drain2 pe1", 32'(res[1]), 32'd99);
        check("drain2 pe1 valid", 32'(rv[1]), 32'd1);
        check("drain2 pe0 valid", 32'(rv[0]), 32'd0);
        tick();
        check("drain3 pe1 valid", 32'(rv[1]), 32'd0);
        shift_en = 1'b0;

        beat(8'd9, 8'd9, 1, 0, 4'b0001);
        beat(8'd9, 8'd9, 0, 0, 4'b0001);
        check("busy before abort", 32'(busy[0]), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async rst busy", 32'(busy[0]), 32'd0);
        check("async rst res_out", 32'(res[0]), 32'd0);
        act[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        beat(8'd7, 8'd6, 1, 1, 4'b0001);
        check("busy after 7x6", 32'(busy[0]), 32'd0);
        check("seq_err after 7x6", 32'(seq[0]), 32'd0);

        beat(8'd1, 8'd1, 0, 1, 4'b0001);
        check("seq_err last w/o first", 32'(seq[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
